// File: rtl/pipeline_run_control_pkg.sv
// Shared types and constants for the pipeline run/debug sequencer.
// State and command encodings plus the pipeline control bundle.
package pipeline_run_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_STEP = 2'b10,
    CMD_HALT = 2'b11
  } cmd_e;

  localparam int DEF_DRAIN_CYCLES = 3;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic stall;
    logic if_flush;
    logic pipe_en;
  } pipe_ctl_t;

  // A halt only counts when it will actually move out of ID.
  function automatic logic halt_seen(
    input logic halt,
    input logic if_id_write,
    input logic stall,
    input logic if_flush
  );
    return halt & if_id_write & stall & ~if_flush;
  endfunction

endpackage

// File: rtl/pipeline_run_control_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;

endmodule

// File: rtl/pipeline_run_control.sv
// Debug run sequencer: gates hazard controls, single-steps
// and drains the pipeline on halt; counts enabled cycles.
module pipeline_run_control
  import pipeline_run_control_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter bit START_RUNNING = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inCmdValid,
  input  logic [1:0]       inCmd,
  output logic             outCmdReady,
  input  logic             inHalt,
  input  logic             inHazPCWrite,
  input  logic             inHazIF_IDWrite,
  input  logic             inHazStall,
  input  logic             inHazIF_Flush,
  output logic             outPCWrite,
  output logic             outIF_IDWrite,
  output logic             outStall,
  output logic             outIF_Flush,
  output logic             outPipeEnable,
  output logic [2:0]       outState,
  output logic [CNT_W-1:0] outCycleCount,
  output logic             outDone
);

  localparam int DW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'(DRAIN_CYCLES - 1);
  localparam state_e RST_STATE =
    START_RUNNING ? ST_RUN : ST_IDLE;

  state_e          r_state;
  logic [DW-1:0]   r_drain;
  logic            r_done;
  pipe_ctl_t       w_ctl;
  cmd_e            w_cmd;
  logic            w_fire;
  logic            w_halt;

  assign w_cmd  = cmd_e'(inCmd);
  assign w_fire = inCmdValid & outCmdReady;
  assign w_halt = halt_seen(inHalt, inHazIF_IDWrite,
                            inHazStall, inHazIF_Flush);

  assign outCmdReady = (r_state == ST_IDLE) ||
                       (r_state == ST_RUN);

  always_comb begin
    w_ctl = '{pc_write: 1'b0, if_id_write: 1'b0,
              stall: 1'b1, if_flush: 1'b0,
              pipe_en: 1'b0};
    case (r_state)
      ST_RUN, ST_STEP: begin
        w_ctl.pc_write    = inHazPCWrite;
        w_ctl.if_id_write = inHazIF_IDWrite;
        w_ctl.stall       = inHazStall;
        w_ctl.if_flush    = inHazIF_Flush;
        w_ctl.pipe_en     = 1'b1;
      end
      ST_DRAIN: begin
        w_ctl.if_id_write = 1'b1;
        w_ctl.if_flush    = 1'b1;
        w_ctl.pipe_en     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RST_STATE;
      r_drain <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            unique case (1'b1)
              (w_cmd == CMD_RUN):  r_state <= ST_RUN;
              (w_cmd == CMD_STEP): r_state <= ST_STEP;
              (w_cmd == CMD_HALT): begin
                r_state <= ST_DRAIN;
                r_drain <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if ((w_fire && (w_cmd == CMD_HALT)) || w_halt) begin
            r_state <= ST_DRAIN;
            r_drain <= '0;
          end
        end
        ST_STEP: begin
          if (w_halt) begin
            r_state <= ST_DRAIN;
            r_drain <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_state <= ST_HALTED;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk     (clk),
    .i_clr   (reset),
    .i_en    (w_ctl.pipe_en),
    .o_count (outCycleCount)
  );

  assign outPCWrite    = w_ctl.pc_write;
  assign outIF_IDWrite = w_ctl.if_id_write;
  assign outStall      = w_ctl.stall;
  assign outIF_Flush   = w_ctl.if_flush;
  assign outPipeEnable = w_ctl.pipe_en;
  assign outState      = r_state;
  assign outDone       = r_done;

endmodule

// File: tb/tb_pipeline_run_control.sv
// Directed scoreboard bench for pipeline_run_control.
// A 4-bit-counter copy shares stimulus for saturation.
module tb_pipeline_run_control;

  logic        clk;
  logic        reset;
  logic        v;
  logic [1:0]  c;
  logic        h;
  logic        hpw, hiw, hst, hfl;

  logic        rdy, pw, iw, st, fl, pe, done;
  logic [2:0]  state;
  logic [31:0] cnt;

  logic        q_rdy, q_pw, q_iw, q_st, q_fl, q_pe, q_done;
  logic [2:0]  q_state;
  logic [3:0]  cnt4;

  int checks;
  int errors;

  typedef struct {
    logic        rdy, pw, iw, st, fl, pe, done;
    logic [2:0]  state;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  int      m_state;
  int      m_dc;
  longint  m_cnt;
  bit      m_done;

  pipeline_run_control dut (
    .clk(clk), .reset(reset),
    .inCmdValid(v), .inCmd(c), .outCmdReady(rdy),
    .inHalt(h), .inHazPCWrite(hpw),
    .inHazIF_IDWrite(hiw), .inHazStall(hst),
    .inHazIF_Flush(hfl),
    .outPCWrite(pw), .outIF_IDWrite(iw),
    .outStall(st), .outIF_Flush(fl),
    .outPipeEnable(pe), .outState(state),
    .outCycleCount(cnt), .outDone(done)
  );

  pipeline_run_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .inCmdValid(v), .inCmd(c), .outCmdReady(q_rdy),
    .inHalt(h), .inHazPCWrite(hpw),
    .inHazIF_IDWrite(hiw), .inHazStall(hst),
    .inHazIF_Flush(hfl),
    .outPCWrite(q_pw), .outIF_IDWrite(q_iw),
    .outStall(q_st), .outIF_Flush(q_fl),
    .outPipeEnable(q_pe), .outState(q_state),
    .outCycleCount(cnt4), .outDone(q_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  localparam logic [3:0] H = 4'b1110;
  localparam logic [3:0] L = 4'b0000;

  task automatic cyc(input bit rst, input bit cv,
                     input logic [1:0] cc, input bit ch,
                     input logic [3:0] hz);
    exp_t e;
    exp_t g;
    bit hs;
    bit fire;
    @(negedge clk);
    reset = rst; v = cv; c = cc; h = ch;
    {hpw, hiw, hst, hfl} = hz;
    e.rdy = (m_state == 0) || (m_state == 1);
    if (m_state == 1 || m_state == 2) begin
      {e.pw, e.iw, e.st, e.fl} = hz;
      e.pe = 1'b1;
    end else if (m_state == 3) begin
      {e.pw, e.iw, e.st, e.fl} = 4'b0111;
      e.pe = 1'b1;
    end else begin
      {e.pw, e.iw, e.st, e.fl} = 4'b0010;
      e.pe = 1'b0;
    end
    e.state = 3'(m_state);
    e.cnt   = 32'(m_cnt);
    e.cnt4  = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
    e.done  = m_done;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      chk("ready", 32'(rdy), 32'(g.rdy));
      chk("pcwrite", 32'(pw), 32'(g.pw));
      chk("ifidwrite", 32'(iw), 32'(g.iw));
      chk("stall", 32'(st), 32'(g.st));
      chk("flush", 32'(fl), 32'(g.fl));
      chk("pipe_en", 32'(pe), 32'(g.pe));
      chk("state", 32'(state), 32'(g.state));
      chk("count", cnt, g.cnt);
      chk("count4", 32'(cnt4), 32'(g.cnt4));
      chk("done", 32'(done), 32'(g.done));
    end
    hs   = ch & hz[2] & hz[1] & ~hz[0];
    fire = cv & e.rdy;
    if (rst) begin
      m_state = 0; m_dc = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (e.pe) m_cnt++;
      case (m_state)
        0: if (fire) begin
          if (cc == 2'b01) m_state = 1;
          else if (cc == 2'b10) m_state = 2;
          else if (cc == 2'b11) begin
            m_state = 3; m_dc = 0;
          end
        end
        1: if ((fire && cc == 2'b11) || hs) begin
          m_state = 3; m_dc = 0;
        end
        2: begin
          m_state = hs ? 3 : 0;
          m_dc = 0;
        end
        3: if (m_dc == 2) begin
          m_state = 4; m_done = 1;
        end else m_dc++;
        default: ;
      endcase
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; v = 0; c = 0; h = 0;
    {hpw, hiw, hst, hfl} = H;
    m_state = 0; m_dc = 0; m_cnt = 0; m_done = 0;
    repeat (2) @(posedge clk);

    // single step
    cyc(0, 0, 2'b00, 0, H);
    cyc(0, 1, 2'b10, 0, H);
    cyc(0, 0, 2'b00, 0, H);
    cyc(0, 0, 2'b00, 0, H);
    sync();
    chk("t1_count", cnt, 32'd1);
    chk("t1_state", 32'(state), 32'd0);

    // step that decodes a halt drains
    cyc(0, 1, 2'b10, 0, H);
    cyc(0, 0, 2'b00, 1, H);
    repeat (3) cyc(0, 0, 2'b00, 0, H);
    cyc(0, 1, 2'b01, 0, H);
    cyc(0, 1, 2'b01, 0, H);
    cyc(1, 0, 2'b00, 0, H);

    // load-use halt ignored, then real halt
    cyc(0, 1, 2'b01, 0, H);
    cyc(0, 0, 2'b00, 1, L);
    cyc(0, 0, 2'b00, 1, H);
    sync();
    chk("t3_state", 32'(state), 32'd3);
    chk("t3_pcw", 32'(pw), 32'd0);
    chk("t3_flush", 32'(fl), 32'd1);
    repeat (3) cyc(0, 0, 2'b00, 0, H);
    cyc(0, 0, 2'b00, 0, H);
    cyc(0, 0, 2'b00, 0, H);
    sync();
    chk("t3_halted", 32'(state), 32'd4);
    chk("t3_done_low", 32'(done), 32'd0);
    cyc(1, 0, 2'b00, 0, H);

    // halt command and halt opcode together
    cyc(0, 1, 2'b01, 0, H);
    cyc(0, 1, 2'b11, 1, H);
    repeat (3) cyc(0, 0, 2'b00, 0, H);
    sync();
    chk("t4_state", 32'(state), 32'd4);
    chk("t4_count", cnt, 32'd4);
    chk("t4_done", 32'(done), 32'd1);
    cyc(1, 0, 2'b00, 0, H);

    // saturation and reset during drain
    cyc(0, 1, 2'b01, 0, H);
    repeat (20) cyc(0, 0, 2'b00, 0, H);
    sync();
    chk("t5_count4", 32'(cnt4), 32'd15);
    chk("t5_count", cnt, 32'd20);
    cyc(0, 1, 2'b11, 0, H);
    cyc(1, 0, 2'b00, 0, H);
    cyc(0, 0, 2'b00, 0, H);
    sync();
    chk("t5_rst_state", 32'(state), 32'd0);
    chk("t5_rst_count", cnt, 32'd0);

    // flushed halt passes through in RUN
    cyc(0, 1, 2'b01, 0, H);
    cyc(0, 0, 2'b00, 1, 4'b1111);
    cyc(0, 1, 2'b10, 0, H);
    cyc(0, 1, 2'b00, 0, H);
    sync();
    chk("t6_state", 32'(state), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
